// File: rtl/monster_pkg.sv
// Shared definitions for the monster game: jump controller state encoding
// and default timing constants reused by the top level and the barrier generator.
package monster_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AIR,
        LAND,
        DUCK,
        HALT
    } jump_state_t;

    localparam int DEB_CYCLES_D     = 4;
    localparam int AIR_TICKS_D      = 3;
    localparam int COOLDOWN_TICKS_D = 2;

    // The controller reports busy while a jump episode (air time or cooldown) is running.
    function automatic logic is_busy(input jump_state_t s);
        return (s == AIR) || (s == LAND);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw push-button.
// level_o is the debounced level delayed by one clk so that it lines up with rise_o,
// the one-cycle pulse marking a debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounced level, its delayed copy and the registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o = level_dly_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/jump_ctrl.sv
// Jump/duck pose controller: turns raw buttons into mutually exclusive up/down
// pose levels, enforces air time and landing cooldown in game ticks and freezes
// while the display reports a collision.
// Optional build macro DOUBLE_JUMP_EN: allows one mid-air jump reload per episode.
module jump_ctrl
    import monster_pkg::*;
#(
    parameter int DEB_CYCLES     = DEB_CYCLES_D,
    parameter int AIR_TICKS      = AIR_TICKS_D,
    parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_D,
    parameter int TICK_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_jump,
    input  logic btn_duck,
    input  logic tick,
    input  logic col,
    output logic up,
    output logic down,
    output logic busy
);

    localparam logic [TICK_W-1:0] AIR_LOAD = TICK_W'(AIR_TICKS);
    localparam logic [TICK_W-1:0] CD_LOAD  = TICK_W'(COOLDOWN_TICKS);
`ifdef DOUBLE_JUMP_EN
    localparam logic [TICK_W-1:0] DJ_WINDOW = TICK_W'(AIR_TICKS / 2);
`endif

    logic              jump_req;
    logic              duck_lvl;
    logic              jump_lvl_unused;
    logic              duck_rise_unused;

    jump_state_t       state_q, state_d;
    logic [TICK_W-1:0] air_cnt_q, air_cnt_d;
    logic [TICK_W-1:0] cd_cnt_q, cd_cnt_d;
    logic              up_q, down_q, busy_q;
`ifdef DOUBLE_JUMP_EN
    logic              dj_used_q, dj_used_d;
`endif

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_jump (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_jump),
        .level_o(jump_lvl_unused),
        .rise_o (jump_req)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_duck (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_duck),
        .level_o(duck_lvl),
        .rise_o (duck_rise_unused)
    );

    // Next-state and counter update; collision overrides everything else.
    always_comb begin
        state_d   = state_q;
        air_cnt_d = air_cnt_q;
        cd_cnt_d  = cd_cnt_q;
`ifdef DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
`endif
        if (col) begin
            state_d   = HALT;
            air_cnt_d = '0;
            cd_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (jump_req) begin
                        state_d   = AIR;
                        air_cnt_d = AIR_LOAD;
                    end else if (duck_lvl) begin
                        state_d = DUCK;
                    end
                end
                DUCK: begin
                    if (jump_req) begin
                        state_d   = AIR;
                        air_cnt_d = AIR_LOAD;
                    end else if (!duck_lvl) begin
                        state_d = IDLE;
                    end
                end
                AIR: begin
`ifdef DOUBLE_JUMP_EN
                    if (jump_req && !dj_used_q && (air_cnt_q <= DJ_WINDOW)) begin
                        air_cnt_d = AIR_LOAD;
                        dj_used_d = 1'b1;
                    end else
`endif
                    if (tick) begin
                        if (air_cnt_q == TICK_W'(1)) begin
                            air_cnt_d = '0;
                            if (COOLDOWN_TICKS == 0) begin
                                state_d = IDLE;
                            end else begin
                                state_d  = LAND;
                                cd_cnt_d = CD_LOAD;
                            end
                        end else begin
                            air_cnt_d = air_cnt_q - TICK_W'(1);
                        end
                    end
                end
                LAND: begin
                    // Jump requests here are simply not looked at, so they are dropped.
                    if (tick) begin
                        if (cd_cnt_q == TICK_W'(1)) begin
                            state_d  = IDLE;
                            cd_cnt_d = '0;
                        end else begin
                            cd_cnt_d = cd_cnt_q - TICK_W'(1);
                        end
                    end
                end
                HALT: begin
                    state_d   = IDLE;
                    air_cnt_d = '0;
                    cd_cnt_d  = '0;
                end
                default: begin
                    state_d   = IDLE;
                    air_cnt_d = '0;
                    cd_cnt_d  = '0;
                end
            endcase
        end
`ifdef DOUBLE_JUMP_EN
        if (state_d != AIR) begin
            dj_used_d = 1'b0;
        end
`endif
    end

    // State, counters and pose outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            air_cnt_q <= '0;
            cd_cnt_q  <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            dj_used_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            air_cnt_q <= air_cnt_d;
            cd_cnt_q  <= cd_cnt_d;
            up_q      <= (state_d == AIR);
            down_q    <= (state_d == DUCK);
            busy_q    <= is_busy(state_d);
`ifdef DOUBLE_JUMP_EN
            dj_used_q <= dj_used_d;
`endif
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign busy = busy_q;

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Upstream stage of the LED-matrix display/barrier block.
- Converts raw jump/duck push-buttons into the clean, mutually exclusive `up`/`down` pose levels the display consumes.
- Enforces jump air-time and landing cooldown in game ticks.
- Freezes on collision (`col` fed back from the display).

Parameters:
- DEB_CYCLES, 4, consecutive synced-stable clk cycles required to accept a button level change (>=1).
- AIR_TICKS, 3, game ticks `up` is held per jump (>=1).
- COOLDOWN_TICKS, 2, game ticks after landing during which jumps are dropped (0 allowed).
- TICK_W, 4, width of air/cooldown counters; must hold max(AIR_TICKS, COOLDOWN_TICKS).

Ports:
- clk  in  1  system clock; same clock as the display scan.
- rst  in  1  asynchronous, active-low reset.
- btn_jump  in  1  raw, asynchronous jump button, active high.
- btn_duck  in  1  raw, asynchronous duck button, active high.
- tick  in  1  one-clk-wide game-tick pulse, same rate as barrier shifting.
- col  in  1  collision level from the display block.
- up  out  1  registered jump pose.
- down  out  1  registered duck pose.
- busy  out  1  high in AIR or LAND.

Behaviour:
- Reset (rst=0, async): state=IDLE; up=down=busy=0; counters=0; synchronisers and debounced levels=0.
- Input conditioning: each button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level flips only after DEB_CYCLES consecutive synced samples differ from it; any mismatch gap restarts the count.
  - jump_req is a 1-cycle pulse on a rising edge of the debounced jump level.
- Latency: a clean btn_jump rise sampled at edge N gives up=1 at edge N+DEB_CYCLES+3.
- States: IDLE, AIR, LAND, DUCK, HALT. Outputs are registered from the next state, so up/down change on the same edge as the state.
- IDLE (up=0, down=0):
  - jump_req -> AIR, air_cnt=AIR_TICKS.
  - else debounced duck=1 -> DUCK.
  - If both occur in the same cycle, jump wins.
- AIR (up=1):
  - Each tick decrements air_cnt.
  - A tick with air_cnt==1 -> LAND with cd_cnt=COOLDOWN_TICKS; if COOLDOWN_TICKS==0, go straight to IDLE.
  - jump_req in AIR is ignored.
- LAND (up=0, down=0):
  - Each tick decrements cd_cnt; a tick with cd_cnt==1 -> IDLE.
  - jump_req in LAND is dropped, never queued.
- DUCK (down=1):
  - Debounced duck=0 -> IDLE.
  - jump_req -> AIR; down drops on the same edge up rises.
- HALT (up=0, down=0, busy=0):
  - col=1 in any state -> HALT on the next edge; this has priority over every other transition.
  - Stay in HALT while col=1.
  - col=0 -> IDLE with counters cleared. jump_req pulses seen during HALT are discarded.
  - A button still held on exit does not re-trigger; only a new debounced rise does.
- tick coincident with a transition into AIR does not decrement; counting starts from the following tick.
- Invariant: up & down is never 1.
- Reset asserted mid-AIR: up falls asynchronously; no residual state after rst rises.

Optional Feature:
- Macro: DOUBLE_JUMP_EN.
- Defined:
  - One jump_req accepted per AIR episode, only while air_cnt<=AIR_TICKS/2 (integer division).
  - On acceptance, air_cnt reloads to AIR_TICKS and up stays 1.
  - A one-bit dj_used flag blocks further reloads and clears on LAND/IDLE/HALT.
- Undefined: jump_req in AIR is always ignored; no dj_used flag exists.

Decomposition:
- Shared package monster_pkg holds:
  - enum jump_state_t {IDLE, AIR, LAND, DUCK, HALT};
  - default constants DEB_CYCLES_D, AIR_TICKS_D, COOLDOWN_TICKS_D, to be reused by the top level and the barrier generator.
- Sub-module btn_debounce (synchroniser + debouncer, parameter DEB_CYCLES, outputs level and rise pulse), instantiated twice.

Test Plan (DEB_CYCLES=4, AIR_TICKS=3, COOLDOWN_TICKS=2, tick every 10 clk):
- Glitch: btn_jump high for 3 clk then low -> up stays 0, state IDLE.
- Clean jump:
  - btn_jump rises at edge 0 and is held -> up=1 at edge 7, busy=1.
  - up=0 exactly on the 3rd tick after entering AIR.
  - A re-press during LAND gives no up.
  - After 2 more ticks the state is IDLE.
- Duck then jump:
  - Hold btn_duck -> down=1 after 7 clk.
  - Press btn_jump while ducking -> up=1 and down=0 on the same edge.
  - Release both after landing -> IDLE.
- Collision mid-AIR: col=1 -> up=0 next edge, HALT for 20 clk; col=0 with btn_jump held -> IDLE, up stays 0.
- Async reset mid-AIR: rst=0 between clock edges -> up=0 immediately; after rst=1 -> IDLE.
- DOUBLE_JUMP_EN defined:
  - Second press after 2 ticks of AIR -> air_cnt=3, up held for 5 ticks total.
  - A third press during the extended AIR is ignored.
